// File: rtl/l2_arb_pkg.sv
// Shared types for the L2 port arbiter: FSM states and grant-pointer sizing.
package l2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/l2_port_arbiter_if.sv
// L2 request port bundle: the arbiter is master, the L2 controller is slave.
interface l2_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
);
  logic              valid_l2;
  logic              rw_l2;
  logic [ADDR_W-1:0] addr_l2;
  logic [LINE_W-1:0] wdata_l2;
  logic              stall_l2;
  logic              done_l2;
  logic [LINE_W-1:0] rdata_l2;

  modport master (
    output valid_l2, rw_l2, addr_l2, wdata_l2,
    input  stall_l2, done_l2, rdata_l2
  );

  modport slave (
    input  valid_l2, rw_l2, addr_l2, wdata_l2,
    output stall_l2, done_l2, rdata_l2
  );
endinterface

// File: rtl/rr_arbiter_pick.sv
// Combinational rotate-priority picker: first set request after last_i, wrapping.
module rr_arbiter_pick
  import l2_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = ptr_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   last_i,
  output logic [PTR_W-1:0]   grant_o,
  output logic               any_o
);

  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    // Upper half (above last grant) has priority over the wrapped lower half.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any_o && req_i[i] && (PTR_W'(i) > last_i)) begin
        grant_o = PTR_W'(i);
        any_o   = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any_o && req_i[i] && (PTR_W'(i) <= last_i)) begin
        grant_o = PTR_W'(i);
        any_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l2_port_arbiter.sv
// Round-robin owner of the single L2 port; one transaction per grant, completion routed to the owner.
// Request -> valid_l2 one cycle later; done_l2 -> req_done one cycle later. stall_l2 only gates new grants.
module l2_port_arbiter
  import l2_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_rw,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LINE_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [LINE_W-1:0]         req_rdata,
  output logic [NUM_REQ-1:0]        req_busy,
  output logic                      err_spur,
  l2_port_arbiter_if.master         l2
);

  localparam int PTR_W = ptr_w(NUM_REQ);

  arb_state_e        state_q, state_d;
  logic [PTR_W-1:0]  grant_q, grant_d, last_q, last_d, pick_idx;
  logic              pick_any;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              in_flight;

  logic [ADDR_W-1:0] addr_a  [NUM_REQ];
  logic [LINE_W-1:0] wdata_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_a[g] = req_wdata[g*LINE_W +: LINE_W];
  end

  rr_arbiter_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
    .req_i   (req_valid),
    .last_i  (last_q),
    .grant_o (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    state_d = IDLE;
    grant_d = grant_q;
    last_d  = last_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = '0;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (l2.done_l2) err_d = 1'b1;
        if (pick_any && !l2.stall_l2) begin
          state_d = ISSUE;
          grant_d = pick_idx;
          rw_d    = req_rw[pick_idx];
          addr_d  = addr_a[pick_idx];
          wdata_d = wdata_a[pick_idx];
        end
      end
      ISSUE: begin
        // A completion alongside the strobe cannot belong to this transaction.
        if (l2.done_l2) err_d = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        state_d = WAIT;
        if (l2.done_l2) begin
          state_d = IDLE;
          rdata_d = l2.rdata_l2;
          last_d  = grant_q;
          for (int i = 0; i < NUM_REQ; i++) done_d[i] = (grant_q == PTR_W'(i));
        end
      end
      default: begin
        state_d = IDLE;
        rw_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= PTR_W'(NUM_REQ - 1);
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign in_flight = (state_q == ISSUE) || (state_q == WAIT) || (|done_q);

  always_comb begin
    req_busy = '0;
    for (int i = 0; i < NUM_REQ; i++) req_busy[i] = in_flight && (grant_q != PTR_W'(i));
  end

  assign l2.valid_l2 = (state_q == ISSUE);
  assign l2.rw_l2    = rw_q;
  assign l2.addr_l2  = addr_q;
  assign l2.wdata_l2 = wdata_q;
  assign req_done    = done_q;
  assign req_rdata   = rdata_q;
  assign err_spur    = err_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed vector table plus hand sequences for latching, spurious completions and reset.
module tb_l2_port_arbiter;

  logic         clock = 1'b0;
  logic         reset;
  logic [1:0]   req_valid, req_rw, req_done, req_busy;
  logic [63:0]  req_addr;
  logic [255:0] req_wdata;
  logic [127:0] req_rdata;
  logic         err_spur;
  int           checks = 0;
  int           errors = 0;

  l2_port_arbiter_if #(.ADDR_W(32), .LINE_W(128)) l2 ();

  l2_port_arbiter #(.NUM_REQ(2), .ADDR_W(32), .LINE_W(128)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_done  (req_done),
    .req_rdata (req_rdata),
    .req_busy  (req_busy),
    .err_spur  (err_spur),
    .l2        (l2)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  req;
    logic        stall;
    logic        done;
    logic [7:0]  rd;
    logic [31:0] a0;
    logic [31:0] a1;
    logic        e_vld;
    logic [1:0]  e_done;
    logic [1:0]  e_busy;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic [1:0] req, input logic stall, input logic done,
                              input logic [7:0] rd, input logic [31:0] a0, input logic [31:0] a1,
                              input logic e_vld, input logic [1:0] e_done, input logic [1:0] e_busy,
                              input logic [31:0] e_addr);
    vec_t v;
    v.req = req; v.stall = stall; v.done = done; v.rd = rd; v.a0 = a0; v.a1 = a1;
    v.e_vld = e_vld; v.e_done = e_done; v.e_busy = e_busy; v.e_addr = e_addr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  localparam logic [127:0] W_PAT = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
  localparam logic [127:0] R_PAT = 128'h0BAD_F00D_1357_9BDF_2468_ACE0_5A5A_C3C3;

  initial begin
    reset = 1'b1;
    req_valid = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    l2.stall_l2 = 1'b0; l2.done_l2 = 1'b0; l2.rdata_l2 = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    chk("rst.valid", l2.valid_l2, 0);
    chk("rst.done",  req_done, 0);
    chk("rst.busy",  req_busy, 0);
    chk("rst.addr",  l2.addr_l2, 0);
    chk("rst.err",   err_spur, 0);
    chk("rst.rdata", req_rdata, 0);

    // Single read, alternating contention, stall gating.
    vq.push_back(mk(2'b01, 0, 0, 8'h00, 32'h40,  32'h0,   1, 2'b00, 2'b10, 32'h40));
    repeat (4) vq.push_back(mk(2'b01, 0, 0, 8'h00, 32'h40, 32'h0, 0, 2'b00, 2'b10, 32'h40));
    vq.push_back(mk(2'b01, 0, 1, 8'hA5, 32'h40,  32'h0,   0, 2'b01, 2'b10, 32'h40));
    vq.push_back(mk(2'b00, 0, 0, 8'h00, 32'h40,  32'h0,   0, 2'b00, 2'b00, 32'h40));
    vq.push_back(mk(2'b11, 0, 0, 8'h00, 32'h100, 32'h200, 1, 2'b00, 2'b01, 32'h200));
    vq.push_back(mk(2'b11, 0, 0, 8'h00, 32'h100, 32'h200, 0, 2'b00, 2'b01, 32'h200));
    vq.push_back(mk(2'b11, 0, 1, 8'h11, 32'h100, 32'h200, 0, 2'b10, 2'b01, 32'h200));
    vq.push_back(mk(2'b11, 0, 0, 8'h00, 32'h100, 32'h200, 1, 2'b00, 2'b10, 32'h100));
    vq.push_back(mk(2'b11, 0, 0, 8'h00, 32'h100, 32'h200, 0, 2'b00, 2'b10, 32'h100));
    vq.push_back(mk(2'b11, 0, 1, 8'h22, 32'h100, 32'h200, 0, 2'b01, 2'b10, 32'h100));
    vq.push_back(mk(2'b11, 0, 0, 8'h00, 32'h100, 32'h200, 1, 2'b00, 2'b01, 32'h200));
    vq.push_back(mk(2'b11, 0, 0, 8'h00, 32'h100, 32'h200, 0, 2'b00, 2'b01, 32'h200));
    vq.push_back(mk(2'b11, 0, 1, 8'h33, 32'h100, 32'h200, 0, 2'b10, 2'b01, 32'h200));
    vq.push_back(mk(2'b00, 0, 0, 8'h00, 32'h100, 32'h200, 0, 2'b00, 2'b00, 32'h200));
    repeat (4) vq.push_back(mk(2'b10, 1, 0, 8'h00, 32'h100, 32'h200, 0, 2'b00, 2'b00, 32'h200));
    vq.push_back(mk(2'b10, 0, 0, 8'h00, 32'h100, 32'h200, 1, 2'b00, 2'b01, 32'h200));
    vq.push_back(mk(2'b10, 0, 0, 8'h00, 32'h100, 32'h200, 0, 2'b00, 2'b01, 32'h200));
    vq.push_back(mk(2'b10, 0, 1, 8'h44, 32'h100, 32'h200, 0, 2'b10, 2'b01, 32'h200));
    vq.push_back(mk(2'b00, 0, 0, 8'h00, 32'h100, 32'h200, 0, 2'b00, 2'b00, 32'h200));

    foreach (vq[k]) begin
      req_valid     = vq[k].req;
      req_addr      = {vq[k].a1, vq[k].a0};
      l2.stall_l2   = vq[k].stall;
      l2.done_l2    = vq[k].done;
      l2.rdata_l2   = {16{vq[k].rd}};
      tick();
      chk($sformatf("v%0d.valid", k), l2.valid_l2, vq[k].e_vld);
      chk($sformatf("v%0d.done", k),  req_done,    vq[k].e_done);
      chk($sformatf("v%0d.busy", k),  req_busy,    vq[k].e_busy);
      chk($sformatf("v%0d.addr", k),  l2.addr_l2,  vq[k].e_addr);
      chk($sformatf("v%0d.err", k),   err_spur,    0);
      if (vq[k].e_done != 2'b00) chk($sformatf("v%0d.rdata", k), req_rdata, {16{vq[k].rd}});
    end
    l2.done_l2 = 1'b0;
    l2.stall_l2 = 1'b0;

    // Write-back then read from requester 0; latched fields must ignore input changes.
    req_valid = 2'b01; req_rw = 2'b01; req_addr = {32'h0, 32'h80}; req_wdata = {128'h0, W_PAT};
    tick();
    chk("wb.valid", l2.valid_l2, 1);
    chk("wb.rw",    l2.rw_l2, 1);
    chk("wb.addr",  l2.addr_l2, 32'h80);
    chk("wb.wdata", l2.wdata_l2, W_PAT);
    req_wdata = {128'h0, ~W_PAT}; req_addr = {32'h0, 32'hDEAD};
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("wb.hold%0d.wdata", c), l2.wdata_l2, W_PAT);
      chk($sformatf("wb.hold%0d.addr", c),  l2.addr_l2, 32'h80);
      chk($sformatf("wb.hold%0d.rw", c),    l2.rw_l2, 1);
      chk($sformatf("wb.hold%0d.valid", c), l2.valid_l2, 0);
    end
    l2.done_l2 = 1'b1;
    tick();
    l2.done_l2 = 1'b0;
    chk("wb.done", req_done, 2'b01);
    req_rw = 2'b00; req_addr = {32'h0, 32'hC0};
    tick();
    chk("rd.valid", l2.valid_l2, 1);
    chk("rd.rw",    l2.rw_l2, 0);
    chk("rd.addr",  l2.addr_l2, 32'hC0);
    tick();
    chk("rd.wait", l2.valid_l2, 0);
    l2.done_l2 = 1'b1; l2.rdata_l2 = R_PAT;
    tick();
    l2.done_l2 = 1'b0; req_valid = 2'b00;
    chk("rd.done",  req_done, 2'b01);
    chk("rd.rdata", req_rdata, R_PAT);
    tick();
    chk("rd.idle.done",  req_done, 2'b00);
    chk("rd.idle.valid", l2.valid_l2, 0);

    // Spurious completion while idle is sticky and never completes anyone.
    l2.done_l2 = 1'b1;
    tick();
    l2.done_l2 = 1'b0;
    chk("spur.err",  err_spur, 1);
    chk("spur.done", req_done, 2'b00);
    repeat (3) tick();
    chk("spur.sticky", err_spur, 1);
    chk("spur.valid",  l2.valid_l2, 0);

    // Completion in the strobe cycle is spurious; transaction still waits for a real one.
    reset = 1'b1;
    #1;
    chk("rst2.err", err_spur, 0);
    tick();
    reset = 1'b0;
    req_valid = 2'b01; req_addr = {32'h0, 32'h40};
    tick();
    chk("iss.valid", l2.valid_l2, 1);
    l2.done_l2 = 1'b1;
    tick();
    l2.done_l2 = 1'b0;
    chk("iss.err",  err_spur, 1);
    chk("iss.done", req_done, 2'b00);
    chk("iss.busy", req_busy, 2'b10);
    l2.done_l2 = 1'b1;
    tick();
    l2.done_l2 = 1'b0; req_valid = 2'b00;
    chk("iss.late_done", req_done, 2'b01);
    tick();

    // Reset during WAIT clears everything at once and drops the pending completion.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_valid = 2'b10; req_addr = {32'h300, 32'h0};
    tick();
    chk("rw.grant1", req_busy, 2'b01);
    tick();
    chk("rw.addr", l2.addr_l2, 32'h300);
    #2 reset = 1'b1;
    #1;
    chk("rw.valid", l2.valid_l2, 0);
    chk("rw.busy",  req_busy, 2'b00);
    chk("rw.addr0", l2.addr_l2, 0);
    chk("rw.err",   err_spur, 0);
    chk("rw.done",  req_done, 2'b00);
    tick();
    reset = 1'b0; req_valid = 2'b00;
    l2.done_l2 = 1'b1;
    tick();
    l2.done_l2 = 1'b0;
    chk("rw.late.err",  err_spur, 1);
    chk("rw.late.done", req_done, 2'b00);
    tick();
    chk("rw.after.done", req_done, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
